oversampling_cdr_lock_ctrl: RTL



---
 rtl/cdr_pkg.sv | 22 ++
 rtl/oversampling_cdr_lock_ctrl_if.sv | 24 ++
 rtl/cdr_comma_detect.sv | 46 ++++
 rtl/oversampling_cdr_lock_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// rtl/cdr_pkg.sv - shared state encodings, comma patterns and rate constant for the CDR lock controller
// Contents: FSM state constants, 8b/10b comma patterns (oldest bit in MSB),
// nominal recovered bits per clock, and a comma match helper.
package cdr_pkg;

    typedef logic [1:0] cdr_state_t;

    localparam logic [1:0] ST_RESET   = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [6:0] COMMA_POS = 7'b0011111;
    localparam logic [6:0] COMMA_NEG = 7'b1100000;

    localparam int NOMINAL_BITS_PER_CYCLE = 4;

    function automatic logic is_comma(input logic [6:0] bits);
        return (bits == COMMA_POS) || (bits == COMMA_NEG);
    endfunction

endpackage

// File: rtl/oversampling_cdr_lock_ctrl_if.sv
// rtl/oversampling_cdr_lock_ctrl_if.sv - recovered-data input and lock status bundle of the CDR lock controller
// Signals: rx_data[5]/rx_data_count[3] recovered bits (oldest at rx_data[count-1]);
// cdr_rst, locked, window_bits[16], window_valid, relock_count[8], fault_illegal status.
// master: the side feeding recovered data and observing status; slave: the controller.
interface oversampling_cdr_lock_ctrl_if;
    logic [4:0]  rx_data;
    logic [2:0]  rx_data_count;
    logic        cdr_rst;
    logic        locked;
    logic [15:0] window_bits;
    logic        window_valid;
    logic [7:0]  relock_count;
    logic        fault_illegal;

    modport master (
        output rx_data, rx_data_count,
        input  cdr_rst, locked, window_bits, window_valid, relock_count, fault_illegal
    );

    modport slave (
        input  rx_data, rx_data_count,
        output cdr_rst, locked, window_bits, window_valid, relock_count, fault_illegal
    );
endinterface

// File: rtl/cdr_comma_detect.sv
// rtl/cdr_comma_detect.sv - serial 8b/10b comma detector over the variable-width recovered bit stream
// Ports: clk, rst (async active-high); rx_data[5], rx_data_count[3] in;
// comma_hit out, registered: high the cycle after the cycle in which a comma completed.
module cdr_comma_detect
    import cdr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rx_data,
    input  logic [2:0] rx_data_count,
    output logic       comma_hit
);

    // Newest stream bit sits in hist[0]; a 7-bit slice reads oldest-first from its MSB.
    logic [11:0] hist;
    logic [11:0] hist_next;
    logic [2:0]  shift_n;
    logic [4:0]  keep_mask;
    logic        hit_next;

    always_comb begin
        // Illegal counts contribute no bits to the stream.
        shift_n   = (rx_data_count <= 3'd5) ? rx_data_count : 3'd0;
        keep_mask = 5'((6'd1 << shift_n) - 6'd1);
        hist_next = (hist << shift_n) | {7'd0, rx_data & keep_mask};
        hit_next  = 1'b0;
        // Only slices whose newest bit arrived this cycle complete here, so an
        // old comma is never reported twice.
        for (int i = 0; i < 6; i++) begin
            if ((i < int'(shift_n)) && is_comma(hist_next[i +: 7])) begin
                hit_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            comma_hit <= 1'b0;
        end else begin
            hist      <= hist_next;
            comma_hit <= hit_next;
        end
    end

endmodule

// File: rtl/oversampling_cdr_lock_ctrl.sv
// rtl/oversampling_cdr_lock_ctrl.sv - bring-up sequencer and windowed rate/comma lock monitor for the oversampling CDR
// Ports: clk (312.5 MHz CDR clock), rst (async active-high);
// cdr: slave side of oversampling_cdr_lock_ctrl_if (rx_data/rx_data_count in,
// cdr_rst/locked/window_bits/window_valid/relock_count/fault_illegal out).
module oversampling_cdr_lock_ctrl
    import cdr_pkg::*;
#(
    parameter int RESET_CYCLES  = 128,
    parameter int SETTLE_CYCLES = 1024,
    parameter int WINDOW_CYCLES = 4096,
    parameter int BIT_TOL       = 8,
    parameter int LOCK_WINDOWS  = 4,
    parameter int LOSS_WINDOWS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    oversampling_cdr_lock_ctrl_if.slave  cdr
);

    localparam int EXP_BITS = NOMINAL_BITS_PER_CYCLE * WINDOW_CYCLES;
    localparam int PH_MAX   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int WIN_W    = $clog2(WINDOW_CYCLES + 1);
    localparam int GOOD_W   = $clog2(LOCK_WINDOWS + 1);
    localparam int BAD_W    = $clog2(LOSS_WINDOWS + 1);

    cdr_state_t         state;
    logic [PH_W-1:0]    phase_cnt;
    logic [WIN_W-1:0]   wcnt;
    logic [16:0]        acc;
    logic               win_illegal;
    logic               comma_acc;
    logic               pend_valid;
    logic [16:0]        pend_acc;
    logic               pend_illegal;
    logic [GOOD_W-1:0]  good_cnt;
    logic [BAD_W-1:0]   bad_cnt;

    logic               cdr_rst_q;
    logic               locked_q;
    logic [15:0]        window_bits_q;
    logic               window_valid_q;
    logic [7:0]         relock_q;
    logic               fault_q;

    logic               comma_hit;
    logic               illegal_now;
    logic [17:0]        sum;
    logic [16:0]        acc_next;
    logic               rate_ok;
    logic               window_good;
    int                 diff;

    cdr_comma_detect u_comma (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (cdr.rx_data),
        .rx_data_count (cdr.rx_data_count),
        .comma_hit     (comma_hit)
    );

    always_comb begin
        illegal_now = (cdr.rx_data_count > 3'd5);
        sum         = {1'b0, acc} + {15'd0, (illegal_now ? 3'd0 : cdr.rx_data_count)};
        acc_next    = sum[17] ? 17'h1FFFF : sum[16:0];
        diff        = int'(pend_acc) - EXP_BITS;
        rate_ok     = (diff <= BIT_TOL) && (diff >= -BIT_TOL);
        // The verdict is taken one cycle after the window closes: comma_hit in
        // that cycle reports the window's final input cycle.
        window_good = rate_ok && !pend_illegal && (comma_acc || comma_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RESET;
            phase_cnt      <= '0;
            wcnt           <= '0;
            acc            <= '0;
            win_illegal    <= 1'b0;
            comma_acc      <= 1'b0;
            pend_valid     <= 1'b0;
            pend_acc       <= '0;
            pend_illegal   <= 1'b0;
            good_cnt       <= '0;
            bad_cnt        <= '0;
            cdr_rst_q      <= 1'b1;
            locked_q       <= 1'b0;
            window_bits_q  <= '0;
            window_valid_q <= 1'b0;
            relock_q       <= '0;
            fault_q        <= 1'b0;
        end else begin
            window_valid_q <= 1'b0;
            if (illegal_now) begin
                fault_q <= 1'b1;
            end

            case (state)
                ST_RESET: begin
                    if (phase_cnt == PH_W'(RESET_CYCLES - 1)) begin
                        state     <= ST_SETTLE;
                        phase_cnt <= '0;
                        cdr_rst_q <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (phase_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
                        state       <= ST_MEASURE;
                        phase_cnt   <= '0;
                        wcnt        <= '0;
                        acc         <= '0;
                        win_illegal <= 1'b0;
                        comma_acc   <= 1'b0;
                        pend_valid  <= 1'b0;
                        good_cnt    <= '0;
                        bad_cnt     <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                default: begin
                    // Window framing, shared by ST_MEASURE and ST_LOCKED.
                    pend_valid <= (wcnt == WIN_W'(WINDOW_CYCLES - 1));
                    if (wcnt == WIN_W'(WINDOW_CYCLES - 1)) begin
                        wcnt         <= '0;
                        pend_acc     <= acc_next;
                        pend_illegal <= win_illegal | illegal_now;
                        acc          <= '0;
                        win_illegal  <= 1'b0;
                    end else begin
                        wcnt        <= wcnt + WIN_W'(1);
                        acc         <= acc_next;
                        win_illegal <= win_illegal | illegal_now;
                    end
                    // A hit seen in window cycle 0 belongs to the previous window.
                    comma_acc <= (wcnt == '0) ? 1'b0 : (comma_acc | comma_hit);

                    if (pend_valid) begin
                        window_bits_q  <= pend_acc[16] ? 16'hFFFF : pend_acc[15:0];
                        window_valid_q <= 1'b1;
                        if (state == ST_MEASURE) begin
                            if (window_good) begin
                                good_cnt <= good_cnt + GOOD_W'(1);
                                if (good_cnt == GOOD_W'(LOCK_WINDOWS - 1)) begin
                                    state    <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                    bad_cnt  <= '0;
                                end
                            end else begin
                                state     <= ST_RESET;
                                phase_cnt <= '0;
                                cdr_rst_q <= 1'b1;
                                if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                            end
                        end else begin
                            if (window_good) begin
                                bad_cnt <= '0;
                            end else if (bad_cnt == BAD_W'(LOSS_WINDOWS - 1)) begin
                                locked_q  <= 1'b0;
                                state     <= ST_RESET;
                                phase_cnt <= '0;
                                cdr_rst_q <= 1'b1;
                                if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                            end else begin
                                bad_cnt <= bad_cnt + BAD_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign cdr.cdr_rst       = cdr_rst_q;
    assign cdr.locked        = locked_q;
    assign cdr.window_bits   = window_bits_q;
    assign cdr.window_valid  = window_valid_q;
    assign cdr.relock_count  = relock_q;
    assign cdr.fault_illegal = fault_q;

endmodule
